pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Sequencing controller for the five-stage pipeline's segment registers (IF/ID, ID/EX, EX/MEM, MEM/WB and the PC register). It generates every stage's `bubbleX`/`flushX` pair from cache-miss, load-use and control-transfer conditions. It runs a small post-reset flush sequence, and tracks miss-stall episodes with an FSM. It also keeps saturating performance counters for stall and redirect analysis.

## Interface
- `RST_FLUSH_CYCLES`, 2: cycles of forced pipeline flush after reset, valid range 1..15.
- `CNT_W`, 32: width of each performance counter.
- `clk` in 1: pipeline clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `ICacheMiss` in 1: instruction cache miss pending.
- `DCacheMiss` in 1: data cache miss pending.
- `BranchE` in 1: taken branch resolved in EX.
- `JalrE` in 1: jalr in EX.
- `JalD` in 1: jal decoded in ID.
- `MemToRegE` in 1: EX instruction is a load.
- `RegWriteE` in 1: EX instruction writes a register.
- `RdE` in 5: EX destination register.
- `Rs1D` in 5: ID source register 1.
- `Rs2D` in 5: ID source register 2.
- `Rs1UsedD` in 1: ID instruction reads rs1.
- `Rs2UsedD` in 1: ID instruction reads rs2.
- `cnt_clr` in 1: synchronous clear of all counters.
- `bubbleF`/`flushF`, `bubbleD`/`flushD`, `bubbleE`/`flushE`, `bubbleM`/`flushM`, `bubbleW`/`flushW` out 1 each: segment-register hold/clear controls.
- `stall_cycles` out CNT_W: count of cycles with `bubbleF` = 1 in RUN/MISS.
- `miss_events` out CNT_W: count of RUN->MISS transitions.
- `redirect_events` out CNT_W: count of accepted BranchE/JalrE/JalD redirects.
- `load_use_events` out CNT_W: count of load-use stall cycles.

## Operation
FSM states:

- **INIT**
  - Entered on reset.
  - Outputs: `bubbleF`=1, `flushD`=`flushE`=`flushM`=`flushW`=1, all other controls 0.
  - A down-counter loaded with `RST_FLUSH_CYCLES` decrements each cycle.
  - Goes to RUN on the cycle the counter reaches 1.
  - Inputs are ignored; counters do not increment.
- **RUN**
  - Outputs are Mealy; first matching rule wins.
  - **Miss:** `ICacheMiss` | `DCacheMiss` -> all five bubbles = 1, all flushes = 0; next state MISS; `miss_events`++.
  - **Redirect:** `BranchE` | `JalrE` -> `flushD`=`flushE`=1; `redirect_events`++.
  - **Load-use:** `MemToRegE` & `RegWriteE` & `RdE`≠0 & ((`Rs1UsedD` & `Rs1D`==`RdE`) | (`Rs2UsedD` & `Rs2D`==`RdE`)) -> `bubbleF`=`bubbleD`=1, `flushE`=1; `load_use_events`++.
  - **Jal:** `JalD` -> `flushD`=1; `redirect_events`++.
  - **Otherwise:** all controls 0.
- **MISS**
  - All bubbles = 1 while either miss input is high.
  - On the first cycle both misses are low: outputs are evaluated by the RUN rules in that same cycle, and next state is RUN.
  - Redirect, load-use and jal rules are suppressed while a miss is high. Their conditions persist because the stages are held, so they are re-evaluated on exit.

Rules common to all states:
- A bubble and a flush are never both asserted for the same stage.
- `stall_cycles` increments on every RUN/MISS cycle with `bubbleF`=1.
- Counters saturate at 2^CNT_W−1.
- `cnt_clr` zeroes all counters at the posedge and takes priority over increments in that cycle.
- Counter reset value is 0.

## Timing
- Controls are combinational from state and inputs within the same cycle. Segment registers act on them at the next posedge.
- Counters and state update at posedge, giving 1-cycle latency to visible counter values.
- `rst` asserted mid-operation takes effect immediately (asynchronous). While reset is held, outputs are the INIT pattern and all counters are 0.
- After `rst` is released, INIT lasts exactly `RST_FLUSH_CYCLES` posedges.
- A load-use condition produces exactly one stall cycle when the load advances normally.
- A redirect coinciding with a load-use resolves as redirect: the ID instruction is wrong-path, and the load-use counter does not increment.
- An ICache miss and a DCache miss at the same time count as one miss event.
- A miss that ends and recurs on the next cycle counts as two events.

## Test plan
- **Reset:** `rst` high 3 cycles, then low with `RST_FLUSH_CYCLES`=2 -> INIT pattern for 2 cycles after release, all-zero controls on the 3rd, counters 0.
- **Load-use:** `MemToRegE`=`RegWriteE`=1, `RdE`=5, `Rs2D`=5, `Rs2UsedD`=1 for 1 cycle -> `bubbleF`=`bubbleD`=`flushE`=1, `load_use_events`=1. Repeat with `RdE`=0 -> no stall.
- **Redirect priority:** `BranchE`=1 together with a load-use condition and `JalD`=1 -> only `flushD`=`flushE`; `redirect_events`=1, `load_use_events`=0.
- **DCache miss:** `DCacheMiss` high 4 cycles with `BranchE`=1 -> 4 cycles of all-bubble, then one cycle of `flushD`/`flushE`. Expected counts: `miss_events`=1, `stall_cycles`=4, `redirect_events`=1.
- **Back-to-back misses:** `ICacheMiss` high 2 cycles, low 1, high 1 -> `miss_events`=2, `stall_cycles`=3.
- **Saturation and clear:** with `CNT_W`=4, 20 JalD cycles -> `redirect_events`=15. Then `cnt_clr` together with `JalD` -> 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/sequencing controller: bubble/flush pairs for IF..WB
// segment registers, post-reset flush, miss-stall FSM, perf counters.
//
// Ports:
//   clk, rst             clock, async active-high reset
//   ICacheMiss,DCacheMiss pending cache misses
//   BranchE,JalrE,JalD    control transfers (EX / ID)
//   MemToRegE,RegWriteE,RdE,Rs1D,Rs2D,Rs1UsedD,Rs2UsedD  load-use inputs
//   cnt_clr              synchronous clear of perf counters
//   bubbleX/flushX       hold/clear per segment register (F,D,E,M,W)
//   stall_cycles, miss_events, redirect_events, load_use_events
module pipe_hazard_ctrl #(
  parameter int RST_FLUSH_CYCLES = 2,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ICacheMiss,
  input  logic             DCacheMiss,
  input  logic             BranchE,
  input  logic             JalrE,
  input  logic             JalD,
  input  logic             MemToRegE,
  input  logic             RegWriteE,
  input  logic [4:0]       RdE,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic             Rs1UsedD,
  input  logic             Rs2UsedD,
  input  logic             cnt_clr,
  output logic             bubbleF,
  output logic             flushF,
  output logic             bubbleD,
  output logic             flushD,
  output logic             bubbleE,
  output logic             flushE,
  output logic             bubbleM,
  output logic             flushM,
  output logic             bubbleW,
  output logic             flushW,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] miss_events,
  output logic [CNT_W-1:0] redirect_events,
  output logic [CNT_W-1:0] load_use_events
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_MISS = 2'd2
  } state_t;

  localparam logic [3:0] INIT_LOAD = 4'(RST_FLUSH_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] init_cnt_q, init_cnt_d;

  logic miss, redir, load_use, active;
  logic sel_miss, sel_redir, sel_lu, sel_jal;

  assign miss   = ICacheMiss | DCacheMiss;
  assign redir  = BranchE | JalrE;
  assign active = (state_q != S_INIT);

  assign load_use = MemToRegE & RegWriteE & (RdE != 5'd0) &
                    ((Rs1UsedD & (Rs1D == RdE)) |
                     (Rs2UsedD & (Rs2D == RdE)));

  // First-match-wins priority flattened to one-hot selects. In MISS the
  // miss select covers the held cycles; the exit cycle falls through to
  // the RUN rules because miss is low there.
  assign sel_miss  = active & miss;
  assign sel_redir = active & ~miss & redir;
  assign sel_lu    = active & ~miss & ~redir & load_use;
  assign sel_jal   = active & ~miss & ~redir & ~load_use & JalD;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT;
      init_cnt_q <= INIT_LOAD;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      S_INIT: begin
        init_cnt_d = init_cnt_q - 4'd1;
        if (init_cnt_q <= 4'd1) state_d = S_RUN;
      end
      S_RUN, S_MISS: state_d = miss ? S_MISS : S_RUN;
      default:       state_d = S_INIT;
    endcase
  end

  // Outputs
  always_comb begin
    bubbleF = 1'b0;
    flushF  = 1'b0;
    bubbleD = 1'b0;
    flushD  = 1'b0;
    bubbleE = 1'b0;
    flushE  = 1'b0;
    bubbleM = 1'b0;
    flushM  = 1'b0;
    bubbleW = 1'b0;
    flushW  = 1'b0;
    unique case (1'b1)
      ~active: begin
        bubbleF = 1'b1;
        flushD  = 1'b1;
        flushE  = 1'b1;
        flushM  = 1'b1;
        flushW  = 1'b1;
      end
      sel_miss: begin
        bubbleF = 1'b1;
        bubbleD = 1'b1;
        bubbleE = 1'b1;
        bubbleM = 1'b1;
        bubbleW = 1'b1;
      end
      sel_redir: begin
        flushD = 1'b1;
        flushE = 1'b1;
      end
      sel_lu: begin
        bubbleF = 1'b1;
        bubbleD = 1'b1;
        flushE  = 1'b1;
      end
      sel_jal: flushD = 1'b1;
      default: ;
    endcase
  end

  // Performance counters
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] mev_q, mev_d;
  logic [CNT_W-1:0] red_q, red_d;
  logic [CNT_W-1:0] lu_q, lu_d;

  function automatic logic [CNT_W-1:0] bump(
    input logic [CNT_W-1:0] v,
    input logic             inc
  );
    if (inc && (v != {CNT_W{1'b1}})) return v + 1'b1;
    return v;
  endfunction

  always_comb begin
    stall_d = bump(stall_q, active & bubbleF);
    mev_d   = bump(mev_q, (state_q == S_RUN) & miss);
    red_d   = bump(red_q, sel_redir | sel_jal);
    lu_d    = bump(lu_q, sel_lu);
    if (cnt_clr) begin
      stall_d = '0;
      mev_d   = '0;
      red_d   = '0;
      lu_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      mev_q   <= '0;
      red_q   <= '0;
      lu_q    <= '0;
    end else begin
      stall_q <= stall_d;
      mev_q   <= mev_d;
      red_q   <= red_d;
      lu_q    <= lu_d;
    end
  end

  assign stall_cycles    = stall_q;
  assign miss_events     = mev_q;
  assign redirect_events = red_q;
  assign load_use_events = lu_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus randomized
// stimulus against a rule-level reference model (CNT_W=4).
module tb_pipe_hazard_ctrl;

  localparam int CW  = 4;
  localparam int SAT = 15;

  localparam logic [9:0] INIT_P  = 10'b1001010101;
  localparam logic [9:0] MISS_P  = 10'b1010101010;
  localparam logic [9:0] REDIR_P = 10'b0001010000;
  localparam logic [9:0] LU_P    = 10'b1010010000;
  localparam logic [9:0] JAL_P   = 10'b0001000000;

  logic clk = 1'b0;
  logic rst;
  logic ICacheMiss, DCacheMiss, BranchE, JalrE, JalD;
  logic MemToRegE, RegWriteE, Rs1UsedD, Rs2UsedD, cnt_clr;
  logic [4:0] RdE, Rs1D, Rs2D;
  logic bubbleF, flushF, bubbleD, flushD, bubbleE, flushE;
  logic bubbleM, flushM, bubbleW, flushW;
  logic [CW-1:0] stall_cycles, miss_events;
  logic [CW-1:0] redirect_events, load_use_events;

  wire [9:0] ctrl = {bubbleF, flushF, bubbleD, flushD, bubbleE,
                     flushE, bubbleM, flushM, bubbleW, flushW};
  wire [15:0] cnts = {stall_cycles, miss_events,
                      redirect_events, load_use_events};

  pipe_hazard_ctrl #(.RST_FLUSH_CYCLES(2), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ICacheMiss(ICacheMiss), .DCacheMiss(DCacheMiss),
    .BranchE(BranchE), .JalrE(JalrE), .JalD(JalD),
    .MemToRegE(MemToRegE), .RegWriteE(RegWriteE), .RdE(RdE),
    .Rs1D(Rs1D), .Rs2D(Rs2D),
    .Rs1UsedD(Rs1UsedD), .Rs2UsedD(Rs2UsedD),
    .cnt_clr(cnt_clr),
    .bubbleF(bubbleF), .flushF(flushF),
    .bubbleD(bubbleD), .flushD(flushD),
    .bubbleE(bubbleE), .flushE(flushE),
    .bubbleM(bubbleM), .flushM(flushM),
    .bubbleW(bubbleW), .flushW(flushW),
    .stall_cycles(stall_cycles), .miss_events(miss_events),
    .redirect_events(redirect_events),
    .load_use_events(load_use_events)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: cycles left in post-reset flush, whether the
  // previous cycle was a miss cycle, and plain integer counters.
  int m_init;
  bit m_inmiss;
  int m_stall, m_mev, m_red, m_lu;

  function automatic bit m_loaduse();
    return MemToRegE && RegWriteE && RdE != 0 &&
           ((Rs1UsedD && Rs1D == RdE) || (Rs2UsedD && Rs2D == RdE));
  endfunction

  function automatic logic [9:0] m_ctrl();
    if (m_init > 0) return INIT_P;
    if (ICacheMiss || DCacheMiss) return MISS_P;
    if (BranchE || JalrE) return REDIR_P;
    if (m_loaduse()) return LU_P;
    if (JalD) return JAL_P;
    return 10'd0;
  endfunction

  function automatic int sat(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  function automatic logic [15:0] m_cnts();
    return {4'(m_stall), 4'(m_mev), 4'(m_red), 4'(m_lu)};
  endfunction

  task automatic m_reset();
    m_init = 2; m_inmiss = 0;
    m_stall = 0; m_mev = 0; m_red = 0; m_lu = 0;
  endtask

  task automatic m_step();
    logic [9:0] c;
    bit miss;
    c = m_ctrl();
    miss = ICacheMiss || DCacheMiss;
    if (m_init > 0) begin
      m_init--;
    end else begin
      if (miss && !m_inmiss) m_mev = sat(m_mev);
      if (c[9]) m_stall = sat(m_stall);
      if (c == REDIR_P || c == JAL_P) m_red = sat(m_red);
      if (c == LU_P) m_lu = sat(m_lu);
      m_inmiss = miss;
    end
    if (cnt_clr) begin
      m_stall = 0; m_mev = 0; m_red = 0; m_lu = 0;
    end
  endtask

  task automatic zero_in();
    ICacheMiss = 0; DCacheMiss = 0; BranchE = 0; JalrE = 0; JalD = 0;
    MemToRegE = 0; RegWriteE = 0; Rs1UsedD = 0; Rs2UsedD = 0;
    cnt_clr = 0; RdE = 0; Rs1D = 0; Rs2D = 0;
  endtask

  // Advance one clock; leaves time at posedge+1.
  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic do_reset();
    zero_in();
    rst = 1'b1;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_lu();
    MemToRegE = 1; RegWriteE = 1; RdE = 5; Rs2D = 5; Rs2UsedD = 1;
  endtask

  task automatic test_reset();
    zero_in();
    rst = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (ctrl !== INIT_P)
      $display("FAIL rst_held_ctrl: got %b want %b", ctrl, INIT_P);
    else n_pass++;
    n_chk++;
    if (cnts !== 16'd0)
      $display("FAIL rst_held_cnts: got %h want 0", cnts);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #4;
      n_chk++;
      if (ctrl !== INIT_P)
        $display("FAIL init_ctrl%0d: got %b want %b", i, ctrl, INIT_P);
      else n_pass++;
      tick();
    end
    JalD = 1;
    #4;
    n_chk++;
    if (ctrl !== 10'd0 && JalD !== 1'b1)
      $display("FAIL run_idle: got %b want 0", ctrl);
    else if (ctrl !== JAL_P)
      $display("FAIL run_first: got %b want %b", ctrl, JAL_P);
    else n_pass++;
    tick();
    tick();
    n_chk++;
    if (redirect_events !== 4'd2)
      $display("FAIL pre_rst_red: got %0d want 2", redirect_events);
    else n_pass++;
    // asynchronous reset mid-operation
    rst = 1'b1;
    m_reset();
    #1;
    n_chk++;
    if (ctrl !== INIT_P || cnts !== 16'd0)
      $display("FAIL async_rst: got %b/%h want %b/0", ctrl, cnts, INIT_P);
    else n_pass++;
    do_reset();
    tick(); tick();
    JalD = 0;
    #4;
    n_chk++;
    if (ctrl !== 10'd0)
      $display("FAIL run_idle: got %b want 0", ctrl);
    else n_pass++;
    tick();
  endtask

  task automatic test_load_use();
    do_reset(); tick(); tick();
    set_lu();
    #4;
    n_chk++;
    if (ctrl !== LU_P)
      $display("FAIL lu_ctrl: got %b want %b", ctrl, LU_P);
    else n_pass++;
    tick();
    n_chk++;
    if (load_use_events !== 4'd1 || stall_cycles !== 4'd1)
      $display("FAIL lu_cnt: got %0d/%0d want 1/1",
               load_use_events, stall_cycles);
    else n_pass++;
    RdE = 0; Rs2D = 0;
    #4;
    n_chk++;
    if (ctrl !== 10'd0)
      $display("FAIL lu_rd0: got %b want 0", ctrl);
    else n_pass++;
    tick();
    n_chk++;
    if (load_use_events !== 4'd1)
      $display("FAIL lu_rd0_cnt: got %0d want 1", load_use_events);
    else n_pass++;
    zero_in();
  endtask

  task automatic test_redirect_priority();
    do_reset(); tick(); tick();
    set_lu(); BranchE = 1; JalD = 1;
    #4;
    n_chk++;
    if (ctrl !== REDIR_P)
      $display("FAIL redir_ctrl: got %b want %b", ctrl, REDIR_P);
    else n_pass++;
    tick();
    n_chk++;
    if (redirect_events !== 4'd1 || load_use_events !== 4'd0)
      $display("FAIL redir_cnt: got %0d/%0d want 1/0",
               redirect_events, load_use_events);
    else n_pass++;
    zero_in();
  endtask

  task automatic test_dmiss();
    do_reset(); tick(); tick();
    DCacheMiss = 1; BranchE = 1;
    for (int i = 0; i < 4; i++) begin
      #4;
      n_chk++;
      if (ctrl !== MISS_P)
        $display("FAIL dmiss_hold%0d: got %b want %b", i, ctrl, MISS_P);
      else n_pass++;
      tick();
    end
    DCacheMiss = 0;
    #4;
    n_chk++;
    if (ctrl !== REDIR_P)
      $display("FAIL dmiss_exit: got %b want %b", ctrl, REDIR_P);
    else n_pass++;
    tick();
    n_chk++;
    if (miss_events !== 4'd1 || stall_cycles !== 4'd4 ||
        redirect_events !== 4'd1)
      $display("FAIL dmiss_cnt: got %0d/%0d/%0d want 1/4/1",
               miss_events, stall_cycles, redirect_events);
    else n_pass++;
    zero_in();
  endtask

  task automatic test_back_to_back();
    do_reset(); tick(); tick();
    ICacheMiss = 1; tick(); tick();
    ICacheMiss = 0; tick();
    ICacheMiss = 1; DCacheMiss = 1; tick();
    ICacheMiss = 0; DCacheMiss = 0; tick();
    n_chk++;
    if (miss_events !== 4'd2 || stall_cycles !== 4'd3)
      $display("FAIL b2b_cnt: got %0d/%0d want 2/3",
               miss_events, stall_cycles);
    else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset(); tick(); tick();
    JalD = 1;
    repeat (20) tick();
    n_chk++;
    if (redirect_events !== 4'd15)
      $display("FAIL sat_red: got %0d want 15", redirect_events);
    else n_pass++;
    cnt_clr = 1;
    tick();
    n_chk++;
    if (redirect_events !== 4'd0)
      $display("FAIL clr_red: got %0d want 0", redirect_events);
    else n_pass++;
    zero_in();
  endtask

  task automatic test_random();
    int bad_c = 0;
    int bad_n = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      ICacheMiss = ($urandom_range(0, 7) == 0);
      DCacheMiss = ($urandom_range(0, 9) == 0);
      BranchE    = ($urandom_range(0, 7) == 0);
      JalrE      = ($urandom_range(0, 11) == 0);
      JalD       = ($urandom_range(0, 5) == 0);
      MemToRegE  = ($urandom_range(0, 2) == 0);
      RegWriteE  = ($urandom_range(0, 3) != 0);
      Rs1UsedD   = $urandom_range(0, 1);
      Rs2UsedD   = $urandom_range(0, 1);
      RdE        = 5'($urandom_range(0, 3));
      Rs1D       = 5'($urandom_range(0, 3));
      Rs2D       = 5'($urandom_range(0, 3));
      cnt_clr    = ($urandom_range(0, 29) == 0);
      #4;
      n_chk++;
      if (ctrl !== m_ctrl()) begin
        if (bad_c < 5)
          $display("FAIL rnd_ctrl@%0d: got %b want %b", i, ctrl, m_ctrl());
        bad_c++;
      end else n_pass++;
      tick();
      n_chk++;
      if (cnts !== m_cnts()) begin
        if (bad_n < 5)
          $display("FAIL rnd_cnts@%0d: got %h want %h", i, cnts, m_cnts());
        bad_n++;
      end else n_pass++;
    end
    zero_in();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect_priority();
    test_dmiss();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
